// File: rtl/vector_pack_64_pkg.sv
// Shared constants and state encoding for the activation packer,
// the column-split stage and the PE array.
package vector_pack_64_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_ELEM = 64;
  localparam int VEC_W    = NUM_ELEM * DATA_W;
  localparam int LANES    = 4;
  localparam int BEATS    = NUM_ELEM / LANES;
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/vector_pack_64.sv
// Serial-to-parallel packer: LANES-wide beats of signed 16-bit elements
// gathered into one 1024-bit vector, double-buffered behind valid/ready.
module vector_pack_64
  import vector_pack_64_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_data,
  input  logic                     in_last,
  output logic                     vec_valid,
  input  logic                     vec_ready,
  output logic [VEC_W-1:0]         vec_data,
  output logic                     err_short,
  output pack_state_t              state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits for ready, and a producer holding valid keeps
  // its data stable until the transfer.

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  pack_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VEC_W-1:0]  fill_q, fill_d, merged;
  logic              vv_q, vv_d;
  logic [VEC_W-1:0]  vd_q, vd_d;
  logic              err_q, err_d;

  logic accept, last_beat, close, slot_free;

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid && in_ready && !clear;
  assign last_beat = (cnt_q == LAST_IDX);
  assign close     = accept && (in_last || last_beat);
  assign slot_free = !vv_q || vec_ready;

  // Element k of the vector sits at beat k/LANES, lane k%LANES, MSB-first.
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    logic hit;
    assign hit = accept && (cnt_q == CNT_W'(b));
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int HI = VEC_W - 1 - (b * LANES + l) * DATA_W;
      assign merged[HI -: DATA_W] = hit ? in_data[l*DATA_W +: DATA_W]
                                        : fill_q[HI -: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    vv_d    = vv_q && !vec_ready;
    vd_d    = vd_q;
    err_d   = err_q;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (in_last && !last_beat) err_d = 1'b1;
          if (close) begin
            if (slot_free) begin
              vd_d   = merged;
              vv_d   = 1'b1;
              cnt_d  = '0;
              fill_d = '0;
            end else begin
              fill_d  = merged;
              state_d = HOLD;
            end
          end else begin
            fill_d = merged;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          vd_d    = fill_q;
          vv_d    = 1'b1;
          cnt_d   = '0;
          fill_d  = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // Flush wins over any transfer on the same edge.
    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
      fill_d  = '0;
      vv_d    = 1'b0;
      vd_d    = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      fill_q  <= '0;
      vv_q    <= 1'b0;
      vd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      vv_q    <= vv_d;
      vd_q    <= vd_d;
      err_q   <= err_d;
    end
  end

  assign vec_valid = vv_q;
  assign vec_data  = vd_q;
  assign err_short = err_q;
  assign state_dbg = state_q;

endmodule
